// File: rtl/platform_collide_engine_pkg.sv
// Shared types, constants and contact evaluation for the platform collision engine.
// The screen 0 platform table lives here; other screens are not populated yet.
package platform_collide_engine_pkg;

  localparam int unsigned COORD_W       = 10;
  localparam int unsigned MAX_PLAT      = 8;
  localparam int unsigned IDX_W         = $clog2(MAX_PLAT);
  localparam int unsigned NUM_SCREENS   = 4;
  localparam int unsigned SEL_W         = 2;
  localparam int unsigned EDGE_W        = COORD_W + 2;
  localparam int          V_MARGIN      = 5;
  localparam int          H_MARGIN      = 2;
  localparam int          SCREEN_TOP    = 5;
  localparam int          SCREEN_BOTTOM = 470;

  typedef logic signed [EDGE_W-1:0] edge_t;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } plat_t;

  typedef struct packed {
    logic bottom;
    logic top;
    logic left;
    logic right;
  } contact_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic edge_t to_edge(input logic [COORD_W-1:0] v);
    return edge_t'({2'b00, v});
  endfunction

  function automatic plat_t mk_plat(input int unsigned x0, input int unsigned x1,
                                    input int unsigned y0, input int unsigned y1);
    plat_t p;
    p.valid = 1'b1;
    p.x_min = COORD_W'(x0);
    p.x_max = COORD_W'(x1);
    p.y_min = COORD_W'(y0);
    p.y_max = COORD_W'(y1);
    return p;
  endfunction

  function automatic plat_t screen0_entry(input logic [IDX_W-1:0] idx);
    plat_t p;
    p = '0;
    case (idx)
      IDX_W'(0): p = mk_plat(0, 639, 407, 479);
      IDX_W'(1): p = mk_plat(110, 210, 240, 407);
      IDX_W'(2): p = mk_plat(432, 532, 240, 407);
      IDX_W'(3): p = mk_plat(265, 378, 80, 130);
      default:   p = '0;
    endcase
    return p;
  endfunction

  // Edges are signed so a box partly off-screen compares correctly.
  function automatic contact_t eval_contact(input plat_t p, input edge_t cl, input edge_t cr,
                                            input edge_t ct, input edge_t cb);
    edge_t    xmin, xmax, ymin, ymax;
    logic     xo, yo;
    contact_t c;
    xmin     = to_edge(p.x_min);
    xmax     = to_edge(p.x_max);
    ymin     = to_edge(p.y_min);
    ymax     = to_edge(p.y_max);
    xo       = (cr > xmin) && (cl < xmax);
    yo       = (cb > ymin) && (ct < ymax);
    c.bottom = p.valid && xo && (cb + edge_t'(V_MARGIN) >= ymin) && (ct < ymin);
    c.top    = p.valid && xo && (ct - edge_t'(V_MARGIN) <= ymax) && (cb > ymax);
    c.left   = p.valid && yo && (cl - edge_t'(H_MARGIN) <= xmax) && (cr > xmax);
    c.right  = p.valid && yo && (cr + edge_t'(H_MARGIN) >= xmin) && (cl < xmin);
    return c;
  endfunction

endpackage

// File: rtl/platform_collide_engine_if.sv
// Request/result bundle between the motion FSM and the collision engine.
interface platform_collide_engine_if;
  import platform_collide_engine_pkg::*;

  logic               start;
  logic [SEL_W-1:0]   screen_sel;
  logic [COORD_W-1:0] Char_X_Pos;
  logic [COORD_W-1:0] Char_Y_Pos;
  logic [COORD_W-1:0] Char_Size;
  logic               busy;
  logic               done;
  logic               bottom_collide;
  logic               top_collide;
  logic               left_collide;
  logic               right_collide;
  logic               ts_collide;
  logic               bs_collide;
  logic               hit_valid;
  logic [IDX_W-1:0]   hit_index;

  modport master (
    output start, screen_sel, Char_X_Pos, Char_Y_Pos, Char_Size,
    input  busy, done, bottom_collide, top_collide, left_collide, right_collide,
    input  ts_collide, bs_collide, hit_valid, hit_index
  );

  modport slave (
    input  start, screen_sel, Char_X_Pos, Char_Y_Pos, Char_Size,
    output busy, done, bottom_collide, top_collide, left_collide, right_collide,
    output ts_collide, bs_collide, hit_valid, hit_index
  );
endinterface

// File: rtl/platform_collide_engine_rom.sv
// Platform table with a one-cycle registered read, addressed by {screen, entry}.
module platform_collide_engine_rom
  import platform_collide_engine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] screen,
  input  logic [IDX_W-1:0] addr,
  output plat_t            data
);

  plat_t lookup;

  always_comb begin
    lookup = '0;
    if (32'(screen) < NUM_SCREENS) begin
      case (screen)
        SEL_W'(0): lookup = screen0_entry(addr);
        default:   lookup = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= lookup;
    end
  end

endmodule

// File: rtl/platform_collide_engine.sv
// Frame-rate collision scan: walks one platform entry per clock, then publishes
// registered contact flags, screen-edge flags and the index of the platform stood on.
module platform_collide_engine
  import platform_collide_engine_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset_n,
  platform_collide_engine_if.slave   bus
);

  state_t             state_q;
  logic [IDX_W-1:0]   addr_q;
  logic [IDX_W-1:0]   eval_idx_q;
  logic               eval_en_q;
  logic [SEL_W-1:0]   sel_q;
  logic [COORD_W-1:0] x_q, y_q, s_q;

  logic               acc_bottom_q, acc_top_q, acc_left_q, acc_right_q;
  logic               acc_hit_valid_q;
  logic [IDX_W-1:0]   acc_hit_idx_q;

  logic               busy_q, done_q;
  logic               bottom_q, top_q, left_q, right_q, ts_q, bs_q, hit_valid_q;
  logic [IDX_W-1:0]   hit_index_q;

  plat_t              rom_data;
  edge_t              cl, cr, ct, cb;
  contact_t           hit;
  logic               nxt_bottom, nxt_top, nxt_left, nxt_right, nxt_hit_valid;
  logic [IDX_W-1:0]   nxt_hit_idx;
  logic               ts_now, bs_now;

  platform_collide_engine_rom u_rom (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .screen (sel_q),
    .addr   (addr_q),
    .data   (rom_data)
  );

  always_comb begin
    cl = to_edge(x_q) - to_edge(s_q);
    cr = to_edge(x_q) + to_edge(s_q);
    ct = to_edge(y_q) - to_edge(s_q);
    cb = to_edge(y_q) + to_edge(s_q);
  end

  // rom_data holds entry eval_idx_q only when eval_en_q is set.
  always_comb begin
    hit           = eval_en_q ? eval_contact(rom_data, cl, cr, ct, cb) : '0;
    nxt_bottom    = acc_bottom_q | hit.bottom;
    nxt_top       = acc_top_q | hit.top;
    nxt_left      = acc_left_q | hit.left;
    nxt_right     = acc_right_q | hit.right;
    nxt_hit_valid = acc_hit_valid_q | hit.bottom;
    nxt_hit_idx   = (!acc_hit_valid_q && hit.bottom) ? eval_idx_q : acc_hit_idx_q;
    ts_now        = (ct - edge_t'(V_MARGIN)) <= edge_t'(SCREEN_TOP);
    bs_now        = (cb + edge_t'(V_MARGIN)) >= edge_t'(SCREEN_BOTTOM);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      eval_idx_q      <= '0;
      eval_en_q       <= 1'b0;
      sel_q           <= '0;
      x_q             <= '0;
      y_q             <= '0;
      s_q             <= '0;
      acc_bottom_q    <= 1'b0;
      acc_top_q       <= 1'b0;
      acc_left_q      <= 1'b0;
      acc_right_q     <= 1'b0;
      acc_hit_valid_q <= 1'b0;
      acc_hit_idx_q   <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      bottom_q        <= 1'b0;
      top_q           <= 1'b0;
      left_q          <= 1'b0;
      right_q         <= 1'b0;
      ts_q            <= 1'b0;
      bs_q            <= 1'b0;
      hit_valid_q     <= 1'b0;
      hit_index_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q         <= S_SCAN;
            busy_q          <= 1'b1;
            sel_q           <= bus.screen_sel;
            x_q             <= bus.Char_X_Pos;
            y_q             <= bus.Char_Y_Pos;
            s_q             <= bus.Char_Size;
            addr_q          <= '0;
            eval_en_q       <= 1'b0;
            acc_bottom_q    <= 1'b0;
            acc_top_q       <= 1'b0;
            acc_left_q      <= 1'b0;
            acc_right_q     <= 1'b0;
            acc_hit_valid_q <= 1'b0;
            acc_hit_idx_q   <= '0;
          end
        end
        S_SCAN: begin
          acc_bottom_q    <= nxt_bottom;
          acc_top_q       <= nxt_top;
          acc_left_q      <= nxt_left;
          acc_right_q     <= nxt_right;
          acc_hit_valid_q <= nxt_hit_valid;
          acc_hit_idx_q   <= nxt_hit_idx;
          eval_en_q       <= 1'b1;
          eval_idx_q      <= addr_q;
          if (addr_q == IDX_W'(MAX_PLAT - 1)) begin
            state_q <= S_DRAIN;
          end else begin
            addr_q <= addr_q + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          // Last entry is folded in directly so results land with the done pulse.
          eval_en_q   <= 1'b0;
          bottom_q    <= nxt_bottom;
          top_q       <= nxt_top;
          left_q      <= nxt_left;
          right_q     <= nxt_right;
          hit_valid_q <= nxt_hit_valid;
          hit_index_q <= nxt_hit_valid ? nxt_hit_idx : '0;
          ts_q        <= ts_now;
          bs_q        <= bs_now;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.bottom_collide = bottom_q;
  assign bus.top_collide    = top_q;
  assign bus.left_collide   = left_q;
  assign bus.right_collide  = right_q;
  assign bus.ts_collide     = ts_q;
  assign bus.bs_collide     = bs_q;
  assign bus.hit_valid      = hit_valid_q;
  assign bus.hit_index      = hit_index_q;

endmodule

// File: tb/tb_platform_collide_engine.sv
// Bench for platform_collide_engine: directed cases plus random boxes against
// a plain-arithmetic model of the screen 0 platform layout.
module tb_platform_collide_engine;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_edge;
  int   done_cnt;

  platform_collide_engine_if bus ();

  platform_collide_engine dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Screen 0 valid platforms; entries 4-7 and screens 1-3 are empty.
  int pxmin[4] = '{0, 110, 432, 265};
  int pxmax[4] = '{639, 210, 532, 378};
  int pymin[4] = '{407, 240, 240, 80};
  int pymax[4] = '{479, 407, 407, 130};

  // Packed result: {bottom, top, left, right, ts, bs, hit_valid, hit_index[2:0]}
  function automatic logic [9:0] model(input int scr, input int x, input int y, input int s);
    int cl, cr, ct, cb, hi;
    bit b, t, l, r, xo, yo, ts, bs;
    cl = x - s; cr = x + s; ct = y - s; cb = y + s;
    b = 0; t = 0; l = 0; r = 0; hi = 0;
    if (scr == 0) begin
      for (int i = 0; i < 4; i++) begin
        xo = (cr > pxmin[i]) && (cl < pxmax[i]);
        yo = (cb > pymin[i]) && (ct < pymax[i]);
        if (xo && cb + 5 >= pymin[i] && ct < pymin[i]) begin
          if (!b) hi = i;
          b = 1;
        end
        if (xo && ct - 5 <= pymax[i] && cb > pymax[i]) t = 1;
        if (yo && cl - 2 <= pxmax[i] && cr > pxmax[i]) l = 1;
        if (yo && cr + 2 >= pxmin[i] && cl < pxmin[i]) r = 1;
      end
    end
    ts = (ct - 5 <= 5);
    bs = (cb + 5 >= 470);
    return {b, t, l, r, ts, bs, b, 3'(hi)};
  endfunction

  function automatic logic [9:0] observed();
    return {bus.bottom_collide, bus.top_collide, bus.left_collide, bus.right_collide,
            bus.ts_collide, bus.bs_collide, bus.hit_valid, bus.hit_index};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one start pulse, scrambles inputs afterwards, and records when done arrives.
  task automatic run_scan(input string tag, input int scr, input int x, input int y,
                          input int s, input bit extra_start);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.screen_sel = 2'(scr);
    bus.Char_X_Pos = 10'(x);
    bus.Char_Y_Pos = 10'(y);
    bus.Char_Size  = 10'(s);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.screen_sel = 2'($urandom_range(0, 3));
    bus.Char_X_Pos = 10'($urandom_range(0, 639));
    bus.Char_Y_Pos = 10'($urandom_range(0, 479));
    bus.Char_Size  = 10'($urandom_range(0, 60));
    done_edge = -1;
    done_cnt  = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      if (n == 1) check({tag, " busy_first"}, 32'(bus.busy), 32'd1);
      if (n == 9) check({tag, " busy_last"}, 32'(bus.busy), 32'd1);
      if (n == 10) check({tag, " busy_drop"}, 32'(bus.busy), 32'd0);
      if (extra_start && n == 2) bus.start = 1'b1;
      if (extra_start && n == 3) bus.start = 1'b0;
    end
    check({tag, " done_latency"}, 32'(done_edge), 32'd9);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic scan_check(input string tag, input int scr, input int x, input int y,
                            input int s, input bit extra_start, input logic [9:0] exp);
    run_scan(tag, scr, x, y, s, extra_start);
    check({tag, " flags"}, 32'(observed()), 32'(exp));
  endtask

  initial begin
    int scr, x, y, s;
    total          = 0;
    bad            = 0;
    bus.start      = 1'b0;
    bus.screen_sel = '0;
    bus.Char_X_Pos = '0;
    bus.Char_Y_Pos = '0;
    bus.Char_Size  = '0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset flags", 32'(observed()), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    scan_check("stand_plat1", 0, 160, 230, 5, 1'b0, 10'b1000_00_1_001);

    // Reset during a scan: everything clears and no done follows.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.screen_sel = 2'd0;
    bus.Char_X_Pos = 10'd320;
    bus.Char_Y_Pos = 10'd140;
    bus.Char_Size  = 10'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset flags", 32'(observed()), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("midreset no_done", 32'(done_cnt), 32'd0);
    check("midreset hold", 32'(observed()), 32'd0);

    scan_check("head_plat3", 0, 320, 140, 5, 1'b0, 10'b0100_00_0_000);
    scan_check("right_plat1", 0, 104, 300, 5, 1'b0, 10'b0001_00_0_000);
    scan_check("right_margin", 0, 102, 300, 5, 1'b0, 10'b0000_00_0_000);
    scan_check("top_edge", 0, 320, 3, 5, 1'b1, 10'b0000_10_0_000);
    scan_check("empty_screen", 3, 160, 230, 5, 1'b0, 10'b0000_00_0_000);
    scan_check("bottom_edge", 3, 160, 470, 5, 1'b0, 10'b0000_01_0_000);

    for (int k = 0; k < 40; k++) begin
      scr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      x   = int'($urandom_range(0, 639));
      y   = int'($urandom_range(0, 479));
      s   = int'($urandom_range(1, 60));
      scan_check($sformatf("rand%0d s%0d x%0d y%0d z%0d", k, scr, x, y, s), scr, x, y, s,
                 1'b0, model(scr, x, y, s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
